display_scan_ctrl: RTL and testbench

Sequencing controller that converts a 14-bit calculator result into four BCD digits and time-multiplexes them onto a 4-digit common-anode 7-segment display. It accepts a new value with a load/busy handshake and converts it by sequential subtraction of decimal weights, one subtraction per cycle, so no dividers are used. It sits between the calculator result register and the board display pins. The displayed digits change only on a completed conversion.

---
 rtl/display_pkg.sv | 36 +++
 rtl/display_scan_ctrl_if.sv | 33 +++
 rtl/seg7_decoder.sv | 14 +
 rtl/display_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display scan controller: FSM states,
// decimal weights, display limits and the BCD to 7-segment lookup.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    // Indexed by digit position: WEIGHT[3]=1000, WEIGHT[2]=100, WEIGHT[1]=10.
    localparam logic [13:0] WEIGHT [3:1] = '{14'd1000, 14'd100, 14'd10};

    localparam logic [13:0] DISP_MAX  = 14'd9999;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    // Active-low segments {g,f,e,d,c,b,a}; non-BCD codes render blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        unique case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load/busy handshake and display pin bundle between the calculator result
// register (master) and the scan controller (slave).
interface display_scan_ctrl_if;

    logic        load_i;
    logic [13:0] number_i;
    logic        busy_o;
    logic        overflow_o;
    logic [3:0]  sel_o;
    logic [3:0]  digit_o;
    logic [6:0]  seg_o;

    modport master (
        output load_i,
        output number_i,
        input  busy_o,
        input  overflow_o,
        input  sel_o,
        input  digit_o,
        input  seg_o
    );

    modport slave (
        input  load_i,
        input  number_i,
        output busy_o,
        output overflow_o,
        output sel_o,
        output digit_o,
        output seg_o
    );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : bcd_to_seg(bcd);
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Binary to BCD converter (repeated subtraction) driving a multiplexed
// 4-digit 7-segment display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    display_scan_ctrl_if.slave  bus
);

    localparam int unsigned    DivW    = $clog2(REFRESH_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);

    state_t           state_q, state_d;
    logic [13:0]      rem_q, rem_d;
    logic [1:0]       p_q, p_d;
    logic [3:0][3:0]  cnt_q, cnt_d;
    logic [3:0][3:0]  disp_q, disp_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic [DivW-1:0]  div_q;
    logic [1:0]       sel_idx_q;
    logic [13:0]      weight;
    logic             blank;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            p_q        <= 2'd3;
            cnt_q      <= '0;
            disp_q     <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        weight = '0;
        for (int i = 1; i <= 3; i++) begin
            if (p_q == 2'(i)) weight = WEIGHT[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load_i) begin
                    rem_d      = (bus.number_i > DISP_MAX) ? DISP_MAX : bus.number_i;
                    ovf_pend_d = (bus.number_i > DISP_MAX);
                    cnt_d      = '0;
                    p_d        = 2'd3;
                    busy_d     = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (rem_q >= weight) begin
                    rem_d      = rem_q - weight;
                    cnt_d[p_q] = cnt_q[p_q] + 4'd1;
                end else if (p_q > 2'd1) begin
                    p_d = p_q - 2'd1;
                end else begin
                    // Remainder is below 10 here, so it is the units digit.
                    cnt_d[0] = rem_q[3:0];
                    state_d  = COMMIT;
                end
            end
            COMMIT: begin
                disp_d  = cnt_q;
                ovf_d   = ovf_pend_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scan, deliberately untouched by conversions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q     <= '0;
            sel_idx_q <= 2'd0;
        end else if (div_q == DivLast) begin
            div_q     <= '0;
            sel_idx_q <= sel_idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank = (sel_idx_q != 2'd0);
        for (int i = 1; i <= 3; i++) begin
            if ((2'(i) >= sel_idx_q) && (disp_q[i] != 4'd0)) blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    seg7_decoder u_seg7_decoder (
        .bcd   (disp_q[sel_idx_q]),
        .blank (blank),
        .seg   (bus.seg_o)
    );

    assign bus.busy_o     = busy_q;
    assign bus.overflow_o = ovf_q;
    assign bus.sel_o      = 4'b0001 << sel_idx_q;
    assign bus.digit_o    = disp_q[sel_idx_q];

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with a short refresh
// period; honours LEADING_ZERO_BLANK_EN when checking segment output.
module tb_display_scan_ctrl;

    localparam int unsigned RefreshDiv = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(
        .REFRESH_DIV (RefreshDiv)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load a value at the current cycle and count the cycles busy stays high.
    task automatic do_load(input logic [13:0] value, output int cycles);
        bus.load_i   = 1'b1;
        bus.number_i = value;
        @(posedge clk);
        #1;
        bus.load_i = 1'b0;
        chk("busy_rise", {31'd0, bus.busy_o}, 32'd1);
        cycles = 1;
        while (bus.busy_o && cycles < 100) begin
            @(posedge clk);
            #1;
            if (bus.busy_o) cycles++;
        end
    endtask

    // Observe one full scan and compare every selected digit and its segments.
    task automatic check_display(input logic [15:0] bcd, input string tag);
        int         idx;
        logic [3:0] nib;
        logic       blank;
        logic [6:0] exp_seg;
        for (int k = 0; k < 4 * RefreshDiv; k++) begin
            @(posedge clk);
            #1;
            case (bus.sel_o)
                4'b0001: idx = 0;
                4'b0010: idx = 1;
                4'b0100: idx = 2;
                4'b1000: idx = 3;
                default: idx = -1;
            endcase
            chk({tag, "_sel_onehot"}, {31'd0, idx >= 0}, 32'd1);
            if (idx >= 0) begin
                nib   = bcd[idx*4 +: 4];
                blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (idx != 0);
                for (int j = idx; j < 4; j++) if (bcd[j*4 +: 4] != 4'd0) blank = 1'b0;
`endif
                exp_seg = blank ? 7'h7F : seg_tab[nib];
                chk({tag, "_digit"}, {28'd0, bus.digit_o}, {28'd0, nib});
                chk({tag, "_seg"}, {25'd0, bus.seg_o}, {25'd0, exp_seg});
            end
        end
    endtask

    initial begin
        int n;
        bus.load_i   = 1'b0;
        bus.number_i = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow_o}, 32'd0);
        chk("rst_sel", {28'd0, bus.sel_o}, 32'd1);
        chk("rst_digit", {28'd0, bus.digit_o}, 32'd0);
        chk("rst_seg", {25'd0, bus.seg_o}, 32'h40);

        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            chk("scan_sel", {28'd0, bus.sel_o}, 32'd1 << ((k / 4) % 4));
            @(posedge clk);
            #1;
        end

        do_load(14'd1234, n);
        chk("busy_1234", n, 10);
        chk("ovf_1234", {31'd0, bus.overflow_o}, 32'd0);
        check_display(16'h1234, "disp_1234");

        do_load(14'd0, n);
        chk("busy_0", n, 4);
        check_display(16'h0000, "disp_0");

        do_load(14'd9999, n);
        chk("busy_9999", n, 31);
        check_display(16'h9999, "disp_9999");

        do_load(14'd12000, n);
        chk("busy_12000", n, 31);
        chk("ovf_12000", {31'd0, bus.overflow_o}, 32'd1);
        check_display(16'h9999, "disp_12000");

        do_load(14'd5, n);
        chk("busy_5", n, 4);
        chk("ovf_5", {31'd0, bus.overflow_o}, 32'd0);
        check_display(16'h0005, "disp_5");

        // Load during a conversion must be ignored.
        do_load(14'd1234, n);
        check_display(16'h1234, "disp_pre");
        bus.load_i   = 1'b1;
        bus.number_i = 14'd1234;
        @(posedge clk);
        #1;
        bus.load_i = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.load_i   = 1'b1;
        bus.number_i = 14'd7;
        @(posedge clk);
        #1;
        bus.load_i = 1'b0;
        n = 4;
        while (bus.busy_o && n < 100) begin
            @(posedge clk);
            #1;
            if (bus.busy_o) n++;
        end
        chk("busy_ignore", n, 10);
        chk("ignore_digit", {28'd0, bus.digit_o},
            {28'd0, 4'(16'h1234 >> (4 * ((bus.sel_o == 4'b0010) ? 1 : (bus.sel_o == 4'b0100)
            ? 2 : (bus.sel_o == 4'b1000) ? 3 : 0)))});
        do_load(14'd42, n);
        chk("busy_42", n, 8);
        check_display(16'h0042, "disp_42");

        // Reset in the middle of a conversion.
        bus.load_i   = 1'b1;
        bus.number_i = 14'd9999;
        @(posedge clk);
        #1;
        bus.load_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, bus.busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("abort_sel", {28'd0, bus.sel_o}, 32'd1);
        chk("abort_digit", {28'd0, bus.digit_o}, 32'd0);
        chk("abort_seg", {25'd0, bus.seg_o}, 32'h40);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_load(14'd42, n);
        chk("busy_after_rst", n, 8);
        check_display(16'h0042, "disp_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
